// File: rtl/dac_pkg.sv
// Shared constants, init ROM, state encoding and sample packing for the
// AD5791-style DAC command scheduler.
package dac_pkg;

  localparam logic [3:0] ADDR_DAC  = 4'b0001;
  localparam logic [3:0] ADDR_CTRL = 4'b0010;
  localparam logic [3:0] ADDR_CLR  = 4'b0011;

  localparam int unsigned INIT_LEN = 3;

  // Control (clamp off, buffer on), clearcode, then DAC at midscale.
  localparam logic [23:0] INIT_ROM [INIT_LEN] = '{
    {ADDR_CTRL, 20'h00008},
    {ADDR_CLR,  20'h00000},
    {ADDR_DAC,  20'h80000}
  };

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  function automatic logic [23:0] pack_sample(input logic [19:0] data20);
    return {ADDR_DAC, data20};
  endfunction

endpackage

// File: rtl/dac_rate_tick.sv
// Sample-slot pacing down-counter: counts DIV-1..0 while enabled, ticks at 0.
module dac_rate_tick #(
  parameter int unsigned DIV = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic load,
  output logic tick
);

  localparam int unsigned W = $clog2(DIV);
  localparam logic [W-1:0] RELOAD = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RELOAD;
    end else if (load) begin
      cnt <= RELOAD;
    end else if (en) begin
      cnt <= (cnt == '0) ? RELOAD : cnt - W'(1);
    end
  end

endmodule

// File: rtl/dac_spi_scheduler.sv
// DAC SPI command scheduler: plays the init sequence, then interleaves paced
// samples with host commands into a single registered output slot.
module dac_spi_scheduler
  import dac_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV = 100,
  parameter int unsigned UNDERRUN_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [23:0]           cmd_tdata,
  input  logic                  cmd_tvalid,
  output logic                  cmd_tready,
  input  logic                  reinit,
  output logic [23:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  init_done,
  output logic [UNDERRUN_W-1:0] underrun_cnt
);

  state_t                  state, state_d;
  logic [1:0]              idx, idx_d;
  logic                    reinit_req, reinit_req_d;
  logic                    sample_pending, sample_pending_d;
  logic [UNDERRUN_W-1:0]   underrun_d;
  logic [23:0]             data_d;
  logic                    valid_d;
  logic                    tick, load_ok, take_s, take_c;

  dac_rate_tick #(.DIV(SAMPLE_DIV)) u_rate_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == RUN),
    .load  (state == INIT),
    .tick  (tick)
  );

  assign load_ok       = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = take_s;
  assign cmd_tready    = take_c;
  assign init_done     = (state == RUN);

  always_comb begin
    state_d          = state;
    idx_d            = idx;
    reinit_req_d     = reinit_req;
    sample_pending_d = sample_pending;
    underrun_d       = underrun_cnt;
    data_d           = m_axis_tdata;
    valid_d          = m_axis_tvalid;
    take_s           = 1'b0;
    take_c           = 1'b0;

    if (m_axis_tvalid && m_axis_tready) valid_d = 1'b0;

    unique case (state)
      INIT: begin
        // idx == INIT_LEN means all ROM words are loaded; wait for the last to leave.
        if (m_axis_tvalid && m_axis_tready && idx == 2'(INIT_LEN)) begin
          state_d = RUN;
        end else if (load_ok && idx < 2'(INIT_LEN)) begin
          valid_d = 1'b1;
          data_d  = INIT_ROM[idx];
          idx_d   = idx + 2'd1;
        end
      end
      RUN: begin
        if (!reinit_req && load_ok) begin
          if (sample_pending && s_axis_tvalid) begin
            take_s  = 1'b1;
            valid_d = 1'b1;
            data_d  = pack_sample(s_axis_tdata[19:0]);
          end else if (cmd_tvalid) begin
            take_c  = 1'b1;
            valid_d = 1'b1;
            data_d  = cmd_tdata;
          end
        end

        // A tick re-arms the slot even when the old one is consumed this cycle.
        if (tick) begin
          if (sample_pending && !take_s && underrun_cnt != '1)
            underrun_d = underrun_cnt + UNDERRUN_W'(1);
          sample_pending_d = 1'b1;
        end else if (take_s) begin
          sample_pending_d = 1'b0;
        end

        if (reinit) reinit_req_d = 1'b1;

        if (reinit_req && load_ok) begin
          state_d          = INIT;
          idx_d            = '0;
          reinit_req_d     = 1'b0;
          sample_pending_d = 1'b0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= INIT;
      idx            <= '0;
      reinit_req     <= 1'b0;
      sample_pending <= 1'b0;
      underrun_cnt   <= '0;
      m_axis_tdata   <= '0;
      m_axis_tvalid  <= 1'b0;
    end else begin
      state          <= state_d;
      idx            <= idx_d;
      reinit_req     <= reinit_req_d;
      sample_pending <= sample_pending_d;
      underrun_cnt   <= underrun_d;
      m_axis_tdata   <= data_d;
      m_axis_tvalid  <= valid_d;
    end
  end

endmodule

// File: tb/tb_dac_spi_scheduler.sv
// Scoreboard bench for dac_spi_scheduler: a behavioural model predicts every
// output word and handshake; a separate monitor pops and compares outputs.
module tb_dac_spi_scheduler;

  localparam int unsigned DIV = 8;
  localparam int unsigned UW  = 4;
  localparam int unsigned UMAX = (1 << UW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [23:0]   cmd_tdata = '0;
  logic          cmd_tvalid = 1'b0;
  logic          cmd_tready;
  logic          reinit = 1'b0;
  logic [23:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          init_done;
  logic [UW-1:0] underrun_cnt;

  dac_spi_scheduler #(.SAMPLE_DIV(DIV), .UNDERRUN_W(UW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .cmd_tdata     (cmd_tdata),
    .cmd_tvalid    (cmd_tvalid),
    .cmd_tready    (cmd_tready),
    .reinit        (reinit),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .init_done     (init_done),
    .underrun_cnt  (underrun_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [23:0] exp_q[$];
  logic [23:0] rom [3] = '{24'h200008, 24'h300000, 24'h180000};

  // Model state: running flag, words issued, cycles since RUN entry, etc.
  bit          mr_run, mr_req, mr_pend, mr_v;
  int unsigned mr_idx, mr_cyc, mr_und;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mr_run = 0; mr_req = 0; mr_pend = 0; mr_v = 0;
    mr_idx = 0; mr_cyc = 0; mr_und = 0;
    exp_q.delete();
  endtask

  always @(negedge clk) begin : model
    bit ld_ok, ts, tc, tk, going;
    if (rst_n) begin
      check("tvalid", m_axis_tvalid, mr_v);
      check("init_done", init_done, mr_run);
      check("underrun", underrun_cnt, mr_und);
      ld_ok = !mr_v || m_axis_tready;
      if (!mr_run) begin
        check("s_tready_init", s_axis_tready, 0);
        check("cmd_tready_init", cmd_tready, 0);
        if (mr_v && m_axis_tready && mr_idx == 3) begin
          mr_run = 1; mr_cyc = 0; mr_v = 0;
        end else if (ld_ok && mr_idx < 3) begin
          exp_q.push_back(rom[mr_idx]);
          mr_idx++;
          mr_v = 1;
        end else if (m_axis_tready) begin
          mr_v = 0;
        end
      end else begin
        tk = (mr_cyc % DIV) == DIV - 1;
        ts = ld_ok && !mr_req && mr_pend && s_axis_tvalid;
        tc = ld_ok && !mr_req && !ts && cmd_tvalid;
        check("s_tready", s_axis_tready, ts);
        check("cmd_tready", cmd_tready, tc);
        if (ts) exp_q.push_back({4'h1, s_axis_tdata[19:0]});
        else if (tc) exp_q.push_back(cmd_tdata);
        going = mr_req && ld_ok;
        if (tk) begin
          if (mr_pend && !ts && mr_und < UMAX) mr_und++;
          mr_pend = 1;
        end else if (ts) begin
          mr_pend = 0;
        end
        if (reinit) mr_req = 1;
        if (ts || tc) mr_v = 1;
        else if (m_axis_tready) mr_v = 0;
        if (going) begin
          mr_run = 0; mr_idx = 0; mr_req = 0; mr_pend = 0;
        end else begin
          mr_cyc++;
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    if (rst_n && m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL m_tdata: got %h expected <no word> at %0t", m_axis_tdata, $time);
      end else begin
        check("m_tdata", m_axis_tdata, exp_q.pop_front());
      end
    end
  end

  task automatic do_reset(input bit rdy);
    @(posedge clk); #1;
    rst_n = 0; s_axis_tvalid = 0; cmd_tvalid = 0; reinit = 0; m_axis_tready = rdy;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_init_done", init_done, 0);
    check("rst_underrun", underrun_cnt, 0);
    check("rst_s_tready", s_axis_tready, 0);
    model_reset();
    rst_n = 1;
  endtask

  task automatic run_phase(input int unsigned n, input int unsigned ps, input int unsigned pc,
                           input int unsigned pr, input int unsigned prei, input bit fixed);
    for (int i = 0; i < int'(n); i++) begin
      @(posedge clk); #1;
      s_axis_tvalid = ($urandom % 100) < ps;
      cmd_tvalid    = ($urandom % 100) < pc;
      m_axis_tready = ($urandom % 100) < pr;
      reinit        = ($urandom % 1000) < prei;
      s_axis_tdata  = fixed ? 32'h00012345 : $urandom;
      cmd_tdata     = fixed ? 24'hABCDEF : 24'($urandom);
    end
  endtask

  initial begin
    bit seen;
    // Power-up init with a free-flowing sink, then idle RUN (underruns build).
    do_reset(1);
    run_phase(40, 0, 0, 100, 0, 1);
    // Sink stalled through INIT, then released.
    do_reset(0);
    run_phase(12, 0, 0, 0, 0, 1);
    run_phase(20, 0, 0, 100, 0, 1);
    // Steady samples, then samples contending with a held command.
    run_phase(60, 100, 0, 100, 0, 1);
    run_phase(60, 100, 100, 100, 0, 1);
    // Missed slots, recovery, and counter saturation.
    run_phase(3 * DIV + 2, 0, 0, 100, 0, 1);
    run_phase(20, 100, 0, 100, 0, 1);
    run_phase(20 * DIV, 0, 30, 100, 0, 0);
    // reinit while a word is held by a stalled sink.
    @(posedge clk); #1;
    s_axis_tvalid = 0; cmd_tvalid = 1; cmd_tdata = 24'h5A5A5A; m_axis_tready = 0;
    @(posedge clk); #1;
    cmd_tvalid = 0; reinit = 1;
    @(posedge clk); #1;
    reinit = 0;
    repeat (3) @(posedge clk);
    #1;
    m_axis_tready = 1;
    run_phase(20, 0, 0, 100, 0, 1);
    // Long randomized mix with occasional reinit.
    run_phase(2000, 50, 50, 70, 5, 0);
    // Reset mid-word drops the in-flight word asynchronously.
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk); #1;
      s_axis_tvalid = 0; cmd_tvalid = 1; reinit = 0; m_axis_tready = 0;
      seen = m_axis_tvalid;
    end
    check("midword_seen", seen, 1);
    #2 rst_n = 0;
    #1;
    check("midword_tvalid", m_axis_tvalid, 0);
    check("midword_tdata", m_axis_tdata, 0);
    do_reset(1);
    run_phase(40, 50, 50, 80, 0, 0);
    // Drain: idle inputs, sink ready, everything predicted must have appeared.
    @(posedge clk); #1;
    s_axis_tvalid = 0; cmd_tvalid = 0; reinit = 0; m_axis_tready = 1;
    repeat (12) @(posedge clk);
    @(negedge clk); #1;
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
